// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller sitting after the MEM stage.
// Bridges loads/stores to a variable-latency backing memory (req/ack),
// stalls the pipeline while an access is outstanding, keeps a one-entry
// doubleword read buffer for zero-latency repeat loads, flags misaligned
// accesses and counts buffer hits / backing-memory accesses.
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   DM_addr           byte address from EX/MEM
//   DM_writeData      store data
//   DM_writeEnable    store request (wins over DM_readEnable)
//   DM_readEnable     load request
//   DM_readData       load data to MEM/WB (combinational)
//   stall             pipeline freeze (combinational)
//   mem_req/mem_we    backing-memory request and direction
//   mem_addr/mem_wdata latched doubleword address / store data
//   mem_ack/mem_rdata backing-memory completion pulse and read data
//   misalign_err      sticky misalignment flag
//   hit_cnt/miss_cnt  saturating buffer-hit / memory-access counters
module dmem_ctrl #(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     DM_addr,
  input  logic [N-1:0]     DM_writeData,
  input  logic             DM_writeEnable,
  input  logic             DM_readEnable,
  output logic [N-1:0]     DM_readData,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic             misalign_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             req_q;
  logic             we_q;
  logic [N-1:0]     addr_q;
  logic [N-1:0]     wdata_q;
  logic             buf_valid_q;
  logic [N-1:0]     buf_tag_q;
  logic [N-1:0]     buf_data_q;
  logic             misalign_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic access;
  logic aligned;
  logic is_read;
  logic hit;
  logic start;
  logic in_idle;

  // Request decode; a simultaneous read+write is treated as a write.
  assign access  = DM_readEnable | DM_writeEnable;
  assign aligned = (DM_addr[2:0] == 3'b000);
  assign is_read = DM_readEnable & ~DM_writeEnable;
  assign in_idle = (state_q == IDLE);
  assign hit     = in_idle & is_read & aligned & buf_valid_q & (buf_tag_q == DM_addr);
  assign start   = in_idle & access & aligned & ~hit;

  // Stall and load data are combinational so a miss freezes the pipe in
  // the same cycle and a hit returns data with zero latency.
  always_comb begin
    stall       = 1'b0;
    DM_readData = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          stall = start;
          if (hit) DM_readData = buf_data_q;
        end
        BUSY: stall = 1'b1;
        DONE: if (!we_q) DM_readData = buf_data_q;
        default: ;
      endcase
    end
  end

  // Controller FSM, request latches, read buffer and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      misalign_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access && !aligned) begin
            misalign_q <= 1'b1;
          end else if (hit) begin
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          end else if (start) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= DM_writeEnable;
            addr_q  <= DM_addr;
            wdata_q <= DM_writeData;
            if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              buf_valid_q <= 1'b1;
              buf_tag_q   <= addr_q;
              buf_data_q  <= mem_rdata;
            end else if (buf_valid_q && (buf_tag_q == addr_q)) begin
              // Write-through keeps the buffered doubleword coherent.
              buf_data_q <= wdata_q;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign misalign_err = misalign_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with hand-computed expectations.
module tb_dmem_ctrl;

  localparam int N     = 64;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [N-1:0]     DM_addr;
  logic [N-1:0]     DM_writeData;
  logic             DM_writeEnable;
  logic             DM_readEnable;
  logic [N-1:0]     DM_readData;
  logic             stall;
  logic             mem_req;
  logic             mem_we;
  logic [N-1:0]     mem_addr;
  logic [N-1:0]     mem_wdata;
  logic             mem_ack;
  logic [N-1:0]     mem_rdata;
  logic             misalign_err;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .misalign_err   (misalign_err),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue an access right after a rising edge and service it: mem_ack is
  // raised in the lat-th cycle mem_req is seen high. Returns at the falling
  // edge of the first non-stalled cycle, with the enables still held.
  task automatic run_access(input logic we, input logic re, input logic [63:0] addr,
                            input logic [63:0] wdata, input int lat,
                            input logic [63:0] rdata, output int stall_n,
                            output int req_n, output logic we_seen);
    bit done;
    @(posedge clk); #1;
    DM_writeEnable = we;
    DM_readEnable  = re;
    DM_addr        = addr;
    DM_writeData   = wdata;
    stall_n = 0;
    req_n   = 0;
    we_seen = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      if (mem_req) begin
        req_n++;
        we_seen = mem_we;
        if (req_n == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    if (!done) begin
      failures++;
      $display("FAIL access_timeout observed=stall_stuck expected=release");
    end
  endtask

  // Drop the enables just after the next rising edge.
  task automatic release_bus();
    @(posedge clk); #1;
    DM_writeEnable = 1'b0;
    DM_readEnable  = 1'b0;
    DM_addr        = '0;
    DM_writeData   = '0;
  endtask

  int   sn, rn;
  logic ws;

  initial begin
    reset          = 1'b1;
    DM_addr        = '0;
    DM_writeData   = '0;
    DM_writeEnable = 1'b0;
    DM_readEnable  = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall",    64'(stall),        64'd0);
    chk("rst_req",      64'(mem_req),      64'd0);
    chk("rst_we",       64'(mem_we),       64'd0);
    chk("rst_addr",     mem_addr,          64'd0);
    chk("rst_wdata",    mem_wdata,         64'd0);
    chk("rst_rdata",    DM_readData,       64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_hit",      64'(hit_cnt),      64'd0);
    chk("rst_miss",     64'(miss_cnt),     64'd0);

    // Read miss, ack latency 3
    run_access(1'b0, 1'b1, 64'h40, 64'h0, 3, 64'hDEAD_BEEF_0000_0001, sn, rn, ws);
    chk("miss_stall_cycles", 64'(sn), 64'd4);
    chk("miss_req_cycles",   64'(rn), 64'd3);
    chk("miss_we",           64'(ws), 64'd0);
    chk("miss_done_data",    DM_readData, 64'hDEAD_BEEF_0000_0001);
    chk("miss_done_req",     64'(mem_req), 64'd0);
    chk("miss_cnt_1",        64'(miss_cnt), 64'd1);
    chk("miss_addr",         mem_addr, 64'h40);
    release_bus();

    // Read hit on the same doubleword
    run_access(1'b0, 1'b1, 64'h40, 64'h0, 1, 64'h0, sn, rn, ws);
    chk("hit_stall_cycles", 64'(sn), 64'd0);
    chk("hit_data",         DM_readData, 64'hDEAD_BEEF_0000_0001);
    chk("hit_req",          64'(mem_req), 64'd0);
    release_bus();
    @(negedge clk);
    chk("hit_cnt_1",  64'(hit_cnt),  64'd1);
    chk("hit_miss_1", 64'(miss_cnt), 64'd1);

    // Write-through to the buffered address, ack latency 1
    run_access(1'b1, 1'b0, 64'h40, 64'h1234, 1, 64'hFFFF, sn, rn, ws);
    chk("wr_stall_cycles", 64'(sn), 64'd2);
    chk("wr_req_cycles",   64'(rn), 64'd1);
    chk("wr_we",           64'(ws), 64'd1);
    chk("wr_done_data",    DM_readData, 64'd0);
    chk("wr_wdata",        mem_wdata, 64'h1234);
    release_bus();

    run_access(1'b0, 1'b1, 64'h40, 64'h0, 1, 64'h0, sn, rn, ws);
    chk("rd_after_wr_stall", 64'(sn), 64'd0);
    chk("rd_after_wr_data",  DM_readData, 64'h1234);
    release_bus();
    @(negedge clk);
    chk("miss_cnt_2", 64'(miss_cnt), 64'd2);
    chk("hit_cnt_2",  64'(hit_cnt),  64'd2);

    // Misaligned read
    run_access(1'b0, 1'b1, 64'h43, 64'h0, 1, 64'h0, sn, rn, ws);
    chk("mis_stall", 64'(sn), 64'd0);
    chk("mis_data",  DM_readData, 64'd0);
    chk("mis_req",   64'(mem_req), 64'd0);
    release_bus();
    @(negedge clk);
    chk("mis_flag",      64'(misalign_err), 64'd1);
    chk("mis_hit_same",  64'(hit_cnt),  64'd2);
    chk("mis_miss_same", 64'(miss_cnt), 64'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mis_sticky", 64'(misalign_err), 64'd1);

    // Read+write together acts as a write; the unrelated write leaves the buffer
    run_access(1'b1, 1'b1, 64'h88, 64'h5555, 2, 64'hAAAA, sn, rn, ws);
    chk("rw_stall_cycles", 64'(sn), 64'd3);
    chk("rw_we",           64'(ws), 64'd1);
    chk("rw_done_data",    DM_readData, 64'd0);
    release_bus();
    run_access(1'b0, 1'b1, 64'h40, 64'h0, 1, 64'h0, sn, rn, ws);
    chk("rw_buf_kept", DM_readData, 64'h1234);
    chk("rw_buf_kept_stall", 64'(sn), 64'd0);
    release_bus();
    @(negedge clk);
    chk("miss_cnt_3", 64'(miss_cnt), 64'd3);

    // Reset in the 2nd BUSY cycle, then a stray ack
    @(posedge clk); #1;
    DM_readEnable = 1'b1;
    DM_addr       = 64'h80;
    @(posedge clk); #1;
    chk("rb_busy1_req", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    chk("rb_busy2_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("rb_req_async",   64'(mem_req),      64'd0);
    chk("rb_stall_async", 64'(stall),        64'd0);
    chk("rb_mis_async",   64'(misalign_err), 64'd0);
    chk("rb_miss_async",  64'(miss_cnt),     64'd0);
    chk("rb_addr_async",  mem_addr,          64'd0);
    DM_readEnable = 1'b0;
    DM_addr       = '0;
    @(negedge clk);
    reset = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 64'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_req",   64'(mem_req),  64'd0);
    chk("stray_stall", 64'(stall),    64'd0);
    chk("stray_miss",  64'(miss_cnt), 64'd0);
    chk("stray_hit",   64'(hit_cnt),  64'd0);

    // Buffer must be invalid after reset: re-reading 0x40 misses
    run_access(1'b0, 1'b1, 64'h40, 64'h0, 1, 64'h9999, sn, rn, ws);
    chk("post_rst_stall", 64'(sn), 64'd2);
    chk("post_rst_data",  DM_readData, 64'h9999);
    release_bus();
    @(negedge clk);
    chk("post_rst_miss", 64'(miss_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
